mac_tx_arbiter: RTL and testbench

- Frame-atomic arbiter that shares the single TSE MAC transmit AXI4-Stream between two byte-wide frame sources.
- Source 0 is the RX-to-TX loopback FIFO output; source 1 is a local packet generator or CPU path.
- Both sources and the MAC are in the `tx_axis_clk` domain.
- Beyond arbitration, the block enforces a programmable inter-frame idle gap and truncates runaway frames.

---
 rtl/mac_tx_arbiter_if.sv | 13 +
 rtl/mac_tx_arbiter.sv | 133 +++++++++++++
 tb/tb_mac_tx_arbiter.sv | 335 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mac_tx_arbiter_if.sv
// mac_tx_arbiter_if: byte-wide AXI4-Stream link carrying a per-frame error flag on tuser.
interface mac_tx_arbiter_if;
    localparam int unsigned DATA_W = 8;

    logic [DATA_W-1:0] tdata;
    logic              tvalid;
    logic              tlast;
    logic              tuser;
    logic              tready;

    modport master (output tdata, output tvalid, output tlast, output tuser, input tready);
    modport slave  (input tdata, input tvalid, input tlast, input tuser, output tready);
endinterface

// File: rtl/mac_tx_arbiter.sv
// mac_tx_arbiter: frame-atomic two-source arbiter for the TSE MAC TX stream with IFG and truncation.
// Optional macro MAC_TX_ARB_FIXED_PRIO_EN: ties always go to source 0 instead of round-robin.
module mac_tx_arbiter #(
    parameter int unsigned IFG_CYCLES    = 2,
    parameter int unsigned MAX_FRAME_LEN = 1514
) (
    input  logic              tx_axis_clk,
    input  logic              tx_axis_rstn,
    mac_tx_arbiter_if.slave   s0_axis,
    mac_tx_arbiter_if.slave   s1_axis,
    mac_tx_arbiter_if.master  tx_axis_mac,
    output logic [1:0]        arb_grant,
    output logic              arb_trunc
);
    localparam int unsigned      DATA_W   = 8;
    localparam int unsigned      CNT_W    = 11;
    localparam int unsigned      GAP_W    = 8;
    localparam logic [CNT_W-1:0] MAX_LEN  = CNT_W'(MAX_FRAME_LEN);
    localparam logic [GAP_W-1:0] IFG_LOAD = GAP_W'(IFG_CYCLES);
    localparam logic             HAS_GAP  = (IFG_CYCLES != 0);

    typedef enum logic [1:0] {IDLE, XFER, DRAIN, GAP} state_t;

    state_t            state;
    logic              owner;
    logic [CNT_W-1:0]  beat_cnt;
    logic [GAP_W-1:0]  gap_cnt;

    logic              src_ready;
    logic              src_valid;
    logic              src_last;
    logic              src_user;
    logic [DATA_W-1:0] src_data;
    logic              accept;
    logic              at_limit;
    logic              pick;
    logic [CNT_W-1:0]  beat_next;

    // Owner may push while the output slot is free or draining this cycle; DRAIN swallows freely.
    assign src_ready      = (state == DRAIN) ||
                            ((state == XFER) && (!tx_axis_mac.tvalid || tx_axis_mac.tready));
    assign s0_axis.tready = src_ready && !owner;
    assign s1_axis.tready = src_ready && owner;

    assign src_valid = owner ? s1_axis.tvalid : s0_axis.tvalid;
    assign src_last  = owner ? s1_axis.tlast  : s0_axis.tlast;
    assign src_user  = owner ? s1_axis.tuser  : s0_axis.tuser;
    assign src_data  = owner ? s1_axis.tdata  : s0_axis.tdata;
    assign accept    = src_valid && src_ready;
    assign beat_next = beat_cnt + CNT_W'(1);
    assign at_limit  = (beat_next == MAX_LEN) && !src_last;

`ifdef MAC_TX_ARB_FIXED_PRIO_EN
    assign pick = !s0_axis.tvalid;
`else
    logic last_grant;

    // Remembers the most recent completed owner so a tie goes to the other source.
    always_ff @(posedge tx_axis_clk or negedge tx_axis_rstn) begin
        if (!tx_axis_rstn) begin
            last_grant <= 1'b1;
        end else if (accept && src_last) begin
            last_grant <= owner;
        end
    end

    assign pick = (s0_axis.tvalid && s1_axis.tvalid) ? !last_grant : !s0_axis.tvalid;
`endif

    always_ff @(posedge tx_axis_clk or negedge tx_axis_rstn) begin
        if (!tx_axis_rstn) begin
            state              <= IDLE;
            owner              <= 1'b0;
            beat_cnt           <= '0;
            gap_cnt            <= '0;
            arb_grant          <= 2'b00;
            arb_trunc          <= 1'b0;
            tx_axis_mac.tdata  <= '0;
            tx_axis_mac.tvalid <= 1'b0;
            tx_axis_mac.tlast  <= 1'b0;
            tx_axis_mac.tuser  <= 1'b0;
        end else begin
            arb_trunc <= 1'b0;

            // Output slot: load on forwarded beat, clear once the MAC took it, else hold.
            if (accept && (state == XFER)) begin
                tx_axis_mac.tdata  <= src_data;
                tx_axis_mac.tvalid <= 1'b1;
                tx_axis_mac.tlast  <= src_last || at_limit;
                tx_axis_mac.tuser  <= (src_user && src_last) || at_limit;
            end else if (tx_axis_mac.tready) begin
                tx_axis_mac.tdata  <= '0;
                tx_axis_mac.tvalid <= 1'b0;
                tx_axis_mac.tlast  <= 1'b0;
                tx_axis_mac.tuser  <= 1'b0;
            end

            case (state)
                IDLE: begin
                    if (s0_axis.tvalid || s1_axis.tvalid) begin
                        owner     <= pick;
                        arb_grant <= pick ? 2'b10 : 2'b01;
                        beat_cnt  <= '0;
                        state     <= XFER;
                    end
                end
                XFER, DRAIN: begin
                    if (accept) begin
                        if (src_last) begin
                            beat_cnt  <= '0;
                            arb_grant <= 2'b00;
                            gap_cnt   <= IFG_LOAD;
                            state     <= HAS_GAP ? GAP : IDLE;
                        end else if (state == XFER) begin
                            beat_cnt <= beat_next;
                            if (at_limit) begin
                                arb_trunc <= 1'b1;
                                state     <= DRAIN;
                            end
                        end
                    end
                end
                GAP: begin
                    gap_cnt <= gap_cnt - GAP_W'(1);
                    if (gap_cnt == GAP_W'(1)) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mac_tx_arbiter.sv
// tb_mac_tx_arbiter: directed frames on both sources, checked per cycle against a frame-level model.
module tb_mac_tx_arbiter;
    localparam int unsigned IFG  = 2;
    localparam int unsigned MAXL = 64;

    logic       tx_axis_clk = 1'b0;
    logic       tx_axis_rstn = 1'b0;
    logic [1:0] arb_grant;
    logic       arb_trunc;

    mac_tx_arbiter_if s0_axis ();
    mac_tx_arbiter_if s1_axis ();
    mac_tx_arbiter_if tx_axis_mac ();

    mac_tx_arbiter #(.IFG_CYCLES(IFG), .MAX_FRAME_LEN(MAXL)) dut (
        .tx_axis_clk  (tx_axis_clk),
        .tx_axis_rstn (tx_axis_rstn),
        .s0_axis      (s0_axis),
        .s1_axis      (s1_axis),
        .tx_axis_mac  (tx_axis_mac),
        .arb_grant    (arb_grant),
        .arb_trunc    (arb_trunc)
    );

    always #5 tx_axis_clk = ~tx_axis_clk;

    typedef struct packed {
        logic [7:0] d;
        logic       l;
        logic       u;
    } beat_t;

    int    n_tests = 0;
    int    n_fail  = 0;
    int    cyc     = 0;
    beat_t q0[$];
    beat_t q1[$];
    beat_t exp_q[$];

    // Model: owner (-1 none), gap cycles left, beats of current frame, drain flag, one-slot output occupancy.
    int    m_own, m_gap, m_last, m_cnt;
    bit    m_drop, m_full, m_trunc;
    bit    rand_ready = 1'b0;

    bit         prev_stall;
    logic [9:0] prev_out;
    bit         in_frame;
    int         cur_len;
    int         first_grant_cyc, first_valid_cyc, trunc_cnt, acc1_cnt;
    logic [7:0] fl_first[$];
    int         fl_len[$];
    int         fl_start[$];
    int         fl_end[$];
    int         fl_user[$];

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @cycle %0d: got 0x%0h expected 0x%0h", name, cyc, act, exp);
        end
    endfunction

    function automatic int qget(input int which, input int idx);
        case (which)
            0: return (idx < fl_first.size()) ? int'(fl_first[idx]) : -1;
            1: return (idx < fl_len.size())   ? fl_len[idx]   : -1;
            2: return (idx < fl_user.size())  ? fl_user[idx]  : -1;
            3: return (idx < fl_start.size()) ? fl_start[idx] : -1;
            default: return (idx < fl_end.size()) ? fl_end[idx] : -1;
        endcase
    endfunction

    function automatic void push_frame(input int src, input int len, input logic [7:0] tag,
                                       input int err_beat, input bit err_last);
        for (int i = 1; i <= len; i++) begin
            beat_t b;
            b.d = tag + 8'(i - 1);
            b.l = (i == len);
            b.u = (i == err_beat) || ((i == len) && err_last);
            if (src == 0) q0.push_back(b);
            else          q1.push_back(b);
        end
    endfunction

    function automatic void model_reset();
        m_own = -1; m_gap = 0; m_last = 1; m_cnt = 0;
        m_drop = 1'b0; m_full = 1'b0; m_trunc = 1'b0;
        q0.delete(); q1.delete(); exp_q.delete();
        prev_stall = 1'b0; in_frame = 1'b0; cur_len = 0;
    endfunction

    function automatic void clear_logs();
        fl_first.delete(); fl_len.delete(); fl_start.delete(); fl_end.delete(); fl_user.delete();
        trunc_cnt = 0; acc1_cnt = 0; first_grant_cyc = -1; first_valid_cyc = -1;
    endfunction

    task automatic drive();
        tx_axis_mac.tready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
        s0_axis.tvalid = (q0.size() > 0);
        if (q0.size() > 0) {s0_axis.tdata, s0_axis.tlast, s0_axis.tuser} = q0[0];
        else               {s0_axis.tdata, s0_axis.tlast, s0_axis.tuser} = '0;
        s1_axis.tvalid = (q1.size() > 0);
        if (q1.size() > 0) {s1_axis.tdata, s1_axis.tlast, s1_axis.tuser} = q1[0];
        else               {s1_axis.tdata, s1_axis.tlast, s1_axis.tuser} = '0;
    endtask

    task automatic check_regs();
        logic [9:0] out_now;
        out_now = {tx_axis_mac.tdata, tx_axis_mac.tlast, tx_axis_mac.tuser};
        chk("arb_grant", 32'(arb_grant), (m_own < 0) ? 32'd0 : ((m_own == 0) ? 32'd1 : 32'd2));
        chk("arb_trunc", 32'(arb_trunc), 32'(m_trunc));
        chk("mac_tvalid", 32'(tx_axis_mac.tvalid), 32'(m_full));
        if (!tx_axis_mac.tvalid) chk("mac_idle_zero", 32'(out_now), 32'd0);
        if (prev_stall) chk("mac_stall_hold", 32'(out_now), 32'(prev_out));
        if (arb_trunc) trunc_cnt++;
        if ((arb_grant != 2'b00) && (first_grant_cyc < 0)) first_grant_cyc = cyc;
        if (tx_axis_mac.tvalid && (first_valid_cyc < 0)) first_valid_cyc = cyc;
    endtask

    task automatic model_step();
        bit    v0, v1, r0, r1, mrdy, acc, push, tr;
        beat_t b0, b1, b, nb, got;
        mrdy = tx_axis_mac.tready;
        v0 = s0_axis.tvalid; b0 = {s0_axis.tdata, s0_axis.tlast, s0_axis.tuser};
        v1 = s1_axis.tvalid; b1 = {s1_axis.tdata, s1_axis.tlast, s1_axis.tuser};
        r0 = (m_own == 0) && (m_drop || !m_full || mrdy);
        r1 = (m_own == 1) && (m_drop || !m_full || mrdy);
        chk("s0_tready", 32'(s0_axis.tready), 32'(r0));
        chk("s1_tready", 32'(s1_axis.tready), 32'(r1));

        // MAC-side scoreboard and frame log
        if (tx_axis_mac.tvalid && mrdy) begin
            got = {tx_axis_mac.tdata, tx_axis_mac.tlast, tx_axis_mac.tuser};
            chk("beat_expected", 32'(exp_q.size() > 0), 32'd1);
            if (exp_q.size() > 0) chk("mac_beat", 32'(got), 32'(exp_q.pop_front()));
            if (!in_frame) begin
                fl_first.push_back(got.d); fl_start.push_back(cyc); cur_len = 0; in_frame = 1'b1;
            end
            cur_len++;
            if (got.l) begin
                fl_len.push_back(cur_len); fl_end.push_back(cyc); fl_user.push_back(int'(got.u));
                in_frame = 1'b0;
            end
        end
        prev_stall = tx_axis_mac.tvalid && !mrdy;
        prev_out   = {tx_axis_mac.tdata, tx_axis_mac.tlast, tx_axis_mac.tuser};

        // Source drivers follow the handshakes actually seen on the bus.
        if (v0 && s0_axis.tready) void'(q0.pop_front());
        if (v1 && s1_axis.tready) begin void'(q1.pop_front()); acc1_cnt++; end

        push = 1'b0; tr = 1'b0;
        if (m_own < 0) begin
            if (m_gap > 0) m_gap--;
            else if (v0 || v1) begin
`ifdef MAC_TX_ARB_FIXED_PRIO_EN
                m_own = v0 ? 0 : 1;
`else
                m_own = (v0 && v1) ? ((m_last == 0) ? 1 : 0) : (v0 ? 0 : 1);
`endif
                m_cnt = 0; m_drop = 1'b0;
            end
        end else begin
            acc = (m_own == 0) ? (v0 && r0) : (v1 && r1);
            b   = (m_own == 0) ? b0 : b1;
            if (acc) begin
                if (!m_drop) begin
                    m_cnt++;
                    if (!b.l && (m_cnt == int'(MAXL))) begin
                        nb = {b.d, 1'b1, 1'b1}; tr = 1'b1; m_drop = 1'b1;
                    end else begin
                        nb = {b.d, b.l, b.l & b.u};
                    end
                    exp_q.push_back(nb); push = 1'b1;
                end
                if (b.l) begin m_last = m_own; m_own = -1; m_gap = int'(IFG); end
            end
        end
        m_full  = push || (m_full && !mrdy);
        m_trunc = tr;
    endtask

    task automatic cycle();
        @(negedge tx_axis_clk);
        cyc++;
        check_regs();
        drive();
        #1;
        model_step();
    endtask

    task automatic run_done(input int budget);
        int n;
        n = 0;
        while (!((q0.size() == 0) && (q1.size() == 0) && (exp_q.size() == 0) &&
                 (m_own < 0) && (m_gap == 0) && !m_full) && (n < budget)) begin
            cycle();
            n++;
        end
        chk("run_within_budget", 32'(n < budget), 32'd1);
        repeat (2) cycle();
    endtask

    task automatic check_rst_zero(input string tag);
        chk({tag, "_tvalid"}, 32'(tx_axis_mac.tvalid), 32'd0);
        chk({tag, "_out"}, 32'({tx_axis_mac.tdata, tx_axis_mac.tlast, tx_axis_mac.tuser}), 32'd0);
        chk({tag, "_grant"}, 32'(arb_grant), 32'd0);
        chk({tag, "_trunc"}, 32'(arb_trunc), 32'd0);
        chk({tag, "_s0_tready"}, 32'(s0_axis.tready), 32'd0);
    endtask

    task automatic do_reset();
        @(negedge tx_axis_clk);
        tx_axis_rstn = 1'b0;
        model_reset();
        drive();
        #1;
        check_rst_zero("rst");
        repeat (2) @(negedge tx_axis_clk);
        tx_axis_rstn = 1'b1;
    endtask

    initial begin
        int n_start;
        int n;
        {s0_axis.tdata, s0_axis.tvalid, s0_axis.tlast, s0_axis.tuser} = '0;
        {s1_axis.tdata, s1_axis.tvalid, s1_axis.tlast, s1_axis.tuser} = '0;
        tx_axis_mac.tready = 1'b1;
        model_reset();

        // Single 60-byte frame after reset: grant at N+1, first beat at N+2
        do_reset();
        clear_logs();
        push_frame(0, 60, 8'h10, 0, 1'b0);
        n_start = cyc + 1;
        run_done(400);
        chk("t1_grant_cycle", 32'(first_grant_cyc), 32'(n_start + 1));
        chk("t1_valid_cycle", 32'(first_valid_cyc), 32'(n_start + 2));
        chk("t1_frames", 32'(fl_len.size()), 32'd1);
        chk("t1_len", 32'(qget(1, 0)), 32'd60);
        chk("t1_user", 32'(qget(2, 0)), 32'd0);

        // Continuous 64-byte frames from both sources; 64 equals the limit so no truncation
        do_reset();
        clear_logs();
        push_frame(0, 64, 8'h10, 0, 1'b0);
        push_frame(0, 64, 8'h30, 0, 1'b0);
        push_frame(1, 64, 8'h20, 0, 1'b0);
        push_frame(1, 64, 8'h40, 0, 1'b0);
        run_done(1000);
`ifdef MAC_TX_ARB_FIXED_PRIO_EN
        chk("t2_order0", 32'(qget(0, 0)), 32'h10);
        chk("t2_order1", 32'(qget(0, 1)), 32'h30);
        chk("t2_order2", 32'(qget(0, 2)), 32'h20);
        chk("t2_order3", 32'(qget(0, 3)), 32'h40);
`else
        chk("t2_order0", 32'(qget(0, 0)), 32'h10);
        chk("t2_order1", 32'(qget(0, 1)), 32'h20);
        chk("t2_order2", 32'(qget(0, 2)), 32'h30);
        chk("t2_order3", 32'(qget(0, 3)), 32'h40);
`endif
        for (int k = 0; k < 4; k++) chk("t2_len", 32'(qget(1, k)), 32'd64);
        for (int k = 0; k < 3; k++) chk("t2_idle_between", 32'(qget(3, k + 1) - qget(4, k) - 1), 32'd3);
        chk("t2_no_trunc", 32'(trunc_cnt), 32'd0);

        // 100-byte frame on s1 is cut at 64, rest drained, then s0 goes
        clear_logs();
        push_frame(1, 100, 8'h80, 0, 1'b0);
        repeat (3) cycle();
        push_frame(0, 20, 8'hC0, 0, 1'b0);
        run_done(1000);
        chk("t3_first_src", 32'(qget(0, 0)), 32'h80);
        chk("t3_trunc_len", 32'(qget(1, 0)), 32'd64);
        chk("t3_trunc_user", 32'(qget(2, 0)), 32'd1);
        chk("t3_trunc_pulses", 32'(trunc_cnt), 32'd1);
        chk("t3_s1_consumed", 32'(acc1_cnt), 32'd100);
        chk("t3_next_src", 32'(qget(0, 1)), 32'hC0);
        chk("t3_next_len", 32'(qget(1, 1)), 32'd20);
        chk("t3_next_user", 32'(qget(2, 1)), 32'd0);

        // Random MAC backpressure; the 200-byte frame also hits the 64-beat limit here
        clear_logs();
        rand_ready = 1'b1;
        push_frame(0, 200, 8'h00, 0, 1'b0);
        repeat (3) cycle();
        push_frame(1, 50, 8'h55, 0, 1'b0);
        run_done(3000);
        rand_ready = 1'b0;
        chk("t4_first_src", 32'(qget(0, 0)), 32'h00);
        chk("t4_first_len", 32'(qget(1, 0)), 32'd64);
        chk("t4_first_user", 32'(qget(2, 0)), 32'd1);
        chk("t4_second_src", 32'(qget(0, 1)), 32'h55);
        chk("t4_second_len", 32'(qget(1, 1)), 32'd50);
        chk("t4_trunc_pulses", 32'(trunc_cnt), 32'd1);

        // tuser only propagates on the tlast beat
        clear_logs();
        push_frame(0, 20, 8'h60, 10, 1'b1);
        repeat (3) cycle();
        push_frame(1, 12, 8'h70, 5, 1'b0);
        run_done(500);
        chk("t5_err_last", 32'(qget(2, 0)), 32'd1);
        chk("t5_err_len", 32'(qget(1, 0)), 32'd20);
        chk("t5_mid_only", 32'(qget(2, 1)), 32'd0);

        // Reset at MAC beat 30 clears outputs at once; next frame starts clean
        clear_logs();
        push_frame(0, 40, 8'h90, 0, 1'b0);
        n = 0;
        while (!(in_frame && (cur_len == 30)) && (n < 300)) begin
            cycle();
            n++;
        end
        chk("t6_reached_beat30", 32'(n < 300), 32'd1);
        tx_axis_rstn = 1'b0;
        #1;
        check_rst_zero("t6_midrst");
        model_reset();
        drive();
        repeat (2) @(negedge tx_axis_clk);
        tx_axis_rstn = 1'b1;
        clear_logs();
        push_frame(1, 10, 8'hE0, 0, 1'b0);
        n_start = cyc + 1;
        run_done(300);
        chk("t6_grant_cycle", 32'(first_grant_cyc), 32'(n_start + 1));
        chk("t6_valid_cycle", 32'(first_valid_cyc), 32'(n_start + 2));
        chk("t6_src", 32'(qget(0, 0)), 32'hE0);
        chk("t6_len", 32'(qget(1, 0)), 32'd10);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
